fifo_rptr_empty: RTL and testbench



---
 rtl/fifo_rptr_empty.sv | 68 ++++++
 tb/tb_fifo_rptr_empty.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rptr_empty.sv
// rtl/fifo_rptr_empty.sv - async FIFO read-domain pointer, empty and fill-level status
// Optional sticky underflow flag enabled by macro FIFO_RD_UNDERFLOW_EN.
module fifo_rptr_empty #(
    parameter int PTR_WIDTH = 4,
    parameter int AE_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic [PTR_WIDTH:0]   rq2_wptr,
    output logic [PTR_WIDTH-1:0] raddr,
    output logic [PTR_WIDTH:0]   rptr,
    output logic                 rempty,
    output logic                 ralmost_empty,
    output logic [PTR_WIDTH:0]   rd_count,
    output logic                 rd_accept
`ifdef FIFO_RD_UNDERFLOW_EN
    ,
    output logic                 rd_underflow
`endif
);

    localparam logic [PTR_WIDTH:0] AE_LIMIT = AE_THRESH[PTR_WIDTH:0];

    logic [PTR_WIDTH:0] rbin;
    logic [PTR_WIDTH:0] rbin_next;
    logic [PTR_WIDTH:0] rgray_next;
    logic [PTR_WIDTH:0] wbin_s;
    logic [PTR_WIDTH:0] count_next;

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i <= PTR_WIDTH; i++) begin : g_gray2bin
        assign wbin_s[i] = ^rq2_wptr[PTR_WIDTH:i];
    end

    assign rd_accept  = rd_en & ~rempty;
    assign rbin_next  = rbin + {{PTR_WIDTH{1'b0}}, rd_accept};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;
    assign count_next = wbin_s - rbin_next;
    assign raddr      = rbin[PTR_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rd_count      <= '0;
        end else begin
            rbin          <= rbin_next;
            rptr          <= rgray_next;
            rempty        <= (rgray_next == rq2_wptr);
            ralmost_empty <= (count_next <= AE_LIMIT);
            rd_count      <= count_next;
        end
    end

`ifdef FIFO_RD_UNDERFLOW_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_underflow <= 1'b0;
        end else if (rd_en && rempty) begin
            rd_underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// tb/tb_fifo_rptr_empty.sv - randomized self-checking bench for fifo_rptr_empty
module tb_fifo_rptr_empty;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_en;
    logic [4:0] rq2_wptr;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] rd_count;
    logic       rd_accept;
`ifdef FIFO_RD_UNDERFLOW_EN
    logic       rd_underflow;
`endif

    always #5 clk = ~clk;

    fifo_rptr_empty #(.PTR_WIDTH(4), .AE_THRESH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_en         (rd_en),
        .rq2_wptr      (rq2_wptr),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rd_count      (rd_count),
        .rd_accept     (rd_accept)
`ifdef FIFO_RD_UNDERFLOW_EN
        ,
        .rd_underflow  (rd_underflow)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: unbounded totals of entries written (as seen after sync) and read.
    int   wr_total;
    int   rd_total;
    int   exp_count;
    logic exp_empty;
    logic exp_ae;
    logic exp_uf;

    function automatic logic [4:0] gray(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_status();
        exp_count = wr_total - rd_total;
        exp_empty = (exp_count == 0);
        exp_ae    = (exp_count <= 2);
    endtask

    task automatic check_outputs();
        chk("rempty", int'(rempty), int'(exp_empty));
        chk("ralmost_empty", int'(ralmost_empty), int'(exp_ae));
        chk("rd_count", int'(rd_count), exp_count);
        chk("rptr", int'(rptr), int'(gray(rd_total)));
        chk("raddr", int'(raddr), rd_total % 16);
`ifdef FIFO_RD_UNDERFLOW_EN
        chk("rd_underflow", int'(rd_underflow), int'(exp_uf));
`endif
    endtask

    task automatic cycle(input logic rd, input int wadd);
        logic       acc;
        logic [4:0] prev;
        @(negedge clk);
        wr_total += wadd;
        rq2_wptr = gray(wr_total);
        rd_en    = rd;
        #1;
        acc = rd && !exp_empty;
        chk("rd_accept", int'(rd_accept), int'(acc));
        prev = rptr;
        @(posedge clk);
        if (rd && exp_empty) exp_uf = 1'b1;
        if (acc) rd_total++;
        model_status();
        #1;
        check_outputs();
        chk("gray_step", $countones(rptr ^ prev), int'(acc));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rd_en    = 1'b0;
        wr_total = 0;
        rd_total = 0;
        rq2_wptr = '0;
        exp_uf   = 1'b0;
        model_status();
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    int lit_rptr[5]  = '{1, 3, 2, 6, 7};
    int lit_count[5] = '{4, 3, 2, 1, 0};

    initial begin
        rst      = 1'b1;
        rd_en    = 1'b0;
        rq2_wptr = '0;
        wr_total = 0;
        rd_total = 0;
        exp_uf   = 1'b0;
        model_status();
        do_reset();

        for (int i = 0; i < 5; i++) cycle(1'b0, 0);
        chk("lit_reset_empty", int'(rempty), 1);
        chk("lit_reset_count", int'(rd_count), 0);

        cycle(1'b0, 5);
        chk("lit_wptr_gray5", int'(rq2_wptr), 7);
        chk("lit_count5", int'(rd_count), 5);
        chk("lit_not_empty", int'(rempty), 0);
        for (int i = 0; i < 5; i++) begin
            chk("lit_raddr_before", int'(raddr), i);
            cycle(1'b1, 0);
            chk("lit_rptr_seq", int'(rptr), lit_rptr[i]);
            chk("lit_count_seq", int'(rd_count), lit_count[i]);
        end
        chk("lit_drained_empty", int'(rempty), 1);

        for (int i = 0; i < 3; i++) cycle(1'b1, 0);
        chk("lit_rptr_held", int'(rptr), 7);

        // Random streaming: several hundred entries, wrapping rbin many times.
        for (int i = 0; i < 600; i++) begin
            int wadd;
            wadd = ((wr_total - rd_total) < 16 && $urandom_range(0, 2) != 0) ? 1 : 0;
            cycle(1'(($urandom_range(0, 3) != 0)), wadd);
        end

        do_reset();
        cycle(1'b0, 16);
        chk("lit_full_wptr", int'(rq2_wptr), 24);
        chk("lit_full_count", int'(rd_count), 16);
        chk("lit_full_ae", int'(ralmost_empty), 0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 0);
        chk("lit_full_drained", int'(rempty), 1);

        do_reset();
        cycle(1'b0, 9);
        cycle(1'b1, 0);
        cycle(1'b1, 0);
        chk("lit_mid_count7", int'(rd_count), 7);
        do_reset();
        chk("lit_async_rptr", int'(rptr), 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
